// File: rtl/program_memory_mp.sv
// Multi-port instruction store: assembles a loader byte stream into words, then serves
// replicated read ports. Optional checksum output enabled by PROGMEM_CHECKSUM_EN.
module program_memory_mp #(
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned DEPTH_WORDS  = 2048,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned RD_LATENCY   = 2,
  parameter bit          BIG_ENDIAN   = 1'b1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic                                 ld_valid_in,
  input  logic [7:0]                           ld_data_in,
  input  logic                                 ld_last_in,
  input  logic                                 reload_in,
  output logic                                 sys_rst_out,
  output logic                                 ready_out,
  output logic                                 overflow_out,
  input  logic [NUM_RD_PORTS-1:0]              rd_req_in,
  input  logic [NUM_RD_PORTS*32-1:0]           rd_addr_in,
  output logic [NUM_RD_PORTS*8*WORD_BYTES-1:0] rd_data_out,
  output logic [NUM_RD_PORTS-1:0]              rd_valid_out,
  output logic [NUM_RD_PORTS-1:0]              rd_err_out
`ifdef PROGMEM_CHECKSUM_EN
  ,
  output logic [31:0]                          checksum_out
`endif
);

  localparam int unsigned DW  = 8 * WORD_BYTES;
  localparam int unsigned SH  = $clog2(WORD_BYTES);
  localparam int unsigned BW  = (WORD_BYTES > 1) ? SH : 1;
  localparam int unsigned AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WCW = AW + 1;

  typedef enum logic [1:0] {ST_LOAD, ST_DONE, ST_READY} state_t;

  state_t          state;
  logic [BW-1:0]   byte_cnt;
  logic [WCW-1:0]  word_cnt;
  logic [DW-1:0]   asm_word;
  logic            closing;
  logic            wr_pend;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
`ifdef PROGMEM_CHECKSUM_EN
  logic [31:0]     cks_q;
  assign checksum_out = cks_q;
`endif

  logic [BW-1:0]   lane;
  logic [DW-1:0]   placed;
  logic [DW-1:0]   asm_next;
  logic            take;
  logic            word_end;
  logic            at_last_word;
  logic            rd_en;

  // Byte lane placement and word assembly
  always_comb begin
    lane         = BIG_ENDIAN ? (BW'(WORD_BYTES - 1) - byte_cnt) : byte_cnt;
    placed       = DW'(ld_data_in) << {lane, 3'b000};
    asm_next     = ((byte_cnt == '0) ? '0 : asm_word) | placed;
    take         = (state == ST_LOAD) && !closing && ld_valid_in;
    word_end     = (byte_cnt == BW'(WORD_BYTES - 1)) || ld_last_in;
    at_last_word = (word_cnt == WCW'(DEPTH_WORDS - 1));
    rd_en        = (state == ST_READY) && !reload_in;
  end

  // Load/ready sequencing; closing holds one cycle so the final word lands before DONE
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_LOAD;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      asm_word     <= '0;
      closing      <= 1'b0;
      wr_pend      <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      sys_rst_out  <= 1'b0;
      ready_out    <= 1'b0;
      overflow_out <= 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
      cks_q        <= '0;
`endif
    end else begin
      wr_pend <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (closing) begin
            closing     <= 1'b0;
            state       <= ST_DONE;
            sys_rst_out <= 1'b1;
            if (ld_valid_in && (word_cnt == WCW'(DEPTH_WORDS))) overflow_out <= 1'b1;
          end else if (take) begin
`ifdef PROGMEM_CHECKSUM_EN
            cks_q <= cks_q + 32'(ld_data_in);
`endif
            if (word_end) begin
              wr_pend  <= 1'b1;
              wr_data  <= asm_next;
              wr_addr  <= word_cnt[AW-1:0];
              word_cnt <= word_cnt + WCW'(1);
              byte_cnt <= '0;
              closing  <= ld_last_in || at_last_word;
            end else begin
              asm_word <= asm_next;
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end
        ST_DONE: begin
          state       <= ST_READY;
          sys_rst_out <= 1'b0;
          ready_out   <= 1'b1;
        end
        ST_READY: begin
          if (reload_in) begin
            state        <= ST_LOAD;
            ready_out    <= 1'b0;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            overflow_out <= 1'b0;
`ifdef PROGMEM_CHECKSUM_EN
            cks_q        <= '0;
`endif
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    logic [DW-1:0] mem_q [DEPTH_WORDS];
    logic [31:0]   addr;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          v_q;
    logic          e_q;
    logic [DW-1:0] d_q;

    assign addr     = rd_addr_in[32*p +: 32];
    assign idx      = addr[SH +: AW];
    assign in_range = (addr >> SH) < 32'(DEPTH_WORDS);
    assign accept   = rd_en && rd_req_in[p];

    // Per-port replica; every replica receives every word write
    always_ff @(posedge clk_in) begin
      if (wr_pend) mem_q[wr_addr] <= wr_data;
    end

    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          v_q <= 1'b0;
          e_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= accept;
          e_q <= accept && !in_range;
          d_q <= (accept && in_range) ? mem_q[idx] : '0;
        end
      end
    end else begin : g_lat2
      logic          s_v;
      logic          s_e;
      logic [DW-1:0] s_d;
      // Second stage squashes anything in flight once READY is left
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          s_v <= 1'b0;
          s_e <= 1'b0;
          s_d <= '0;
          v_q <= 1'b0;
          e_q <= 1'b0;
          d_q <= '0;
        end else begin
          s_v <= accept;
          s_e <= accept && !in_range;
          s_d <= (accept && in_range) ? mem_q[idx] : '0;
          v_q <= s_v && rd_en;
          e_q <= s_e && rd_en;
          d_q <= (s_v && rd_en) ? s_d : '0;
        end
      end
    end

    assign rd_valid_out[p]           = v_q;
    assign rd_err_out[p]             = e_q;
    assign rd_data_out[DW*p +: DW]   = d_q;
  end

endmodule

// File: tb/tb_program_memory_mp.sv
// Bench for program_memory_mp: two instances (BE/2-port/latency 2/depth 4 and
// LE/1-port/latency 1/depth 8) driven by one stimulus, checked against an event-time model.
module tb_program_memory_mp;
  localparam int BIG = 1 << 30;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        ld_valid = 1'b0, ld_last = 1'b0, reload = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic [1:0]  req_a = 2'b00;
  logic [63:0] addr_a = 64'h0;
  logic [63:0] data_a;
  logic [1:0]  valid_a, err_a;
  logic [31:0] data_b;
  logic        valid_b, err_b;
  logic        sysrst_a, ready_a, ovf_a, sysrst_b, ready_b, ovf_b;
`ifdef PROGMEM_CHECKSUM_EN
  logic [31:0] cks_a, cks_b;
`endif

  always #5 clk_in = ~clk_in;

  program_memory_mp #(.WORD_BYTES(4), .DEPTH_WORDS(4), .NUM_RD_PORTS(2), .RD_LATENCY(2), .BIG_ENDIAN(1'b1)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ld_valid_in(ld_valid), .ld_data_in(ld_data),
    .ld_last_in(ld_last), .reload_in(reload), .sys_rst_out(sysrst_a), .ready_out(ready_a),
    .overflow_out(ovf_a), .rd_req_in(req_a), .rd_addr_in(addr_a), .rd_data_out(data_a),
    .rd_valid_out(valid_a), .rd_err_out(err_a)
`ifdef PROGMEM_CHECKSUM_EN
    , .checksum_out(cks_a)
`endif
  );

  program_memory_mp #(.WORD_BYTES(4), .DEPTH_WORDS(8), .NUM_RD_PORTS(1), .RD_LATENCY(1), .BIG_ENDIAN(1'b0)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ld_valid_in(ld_valid), .ld_data_in(ld_data),
    .ld_last_in(ld_last), .reload_in(reload), .sys_rst_out(sysrst_b), .ready_out(ready_b),
    .overflow_out(ovf_b), .rd_req_in(req_a[0]), .rd_addr_in(addr_a[31:0]), .rd_data_out(data_b),
    .rd_valid_out(valid_b), .rd_err_out(err_b)
`ifdef PROGMEM_CHECKSUM_EN
    , .checksum_out(cks_b)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: expected image per instance and the cycles at which status events occur
  typedef struct {int due; logic [31:0] data; logic err; bit known;} exp_t;
  int          ready_from[2] = '{BIG, BIG};
  int          sysrst_cyc[2] = '{-1, -1};
  int          ovf_from[2]   = '{BIG, BIG};
  logic [31:0] exp_sum[2];
  logic [31:0] mem_m[2][8];
  bit          known_m[2][8];
  int          depth_m[2] = '{4, 8};
  bit          be_m[2]    = '{1'b1, 1'b0};
  int          lat_c[3]   = '{2, 2, 1};
  int          dut_c[3]   = '{0, 0, 1};
  exp_t        q[3][$];
  logic [7:0]  stream[32];

  always @(negedge clk_in) begin
    logic [31:0] a, ad, widx;
    logic        av, ae, rq, rdy, act_rdy, act_sr, act_ov;
    exp_t        e;
    if (!rst_n_in) begin
      for (int d = 0; d < 2; d++) begin
        ready_from[d] = BIG; sysrst_cyc[d] = -1; ovf_from[d] = BIG;
      end
      for (int c = 0; c < 3; c++) q[c].delete();
    end
    for (int d = 0; d < 2; d++) begin
      rdy     = (cyc >= ready_from[d]);
      act_rdy = (d == 0) ? ready_a : ready_b;
      act_sr  = (d == 0) ? sysrst_a : sysrst_b;
      act_ov  = (d == 0) ? ovf_a : ovf_b;
      chk($sformatf("ready_d%0d", d), 32'(act_rdy), 32'(rdy));
      chk($sformatf("sys_rst_d%0d", d), 32'(act_sr), 32'(cyc == sysrst_cyc[d]));
      chk($sformatf("overflow_d%0d", d), 32'(act_ov), 32'(cyc >= ovf_from[d]));
`ifdef PROGMEM_CHECKSUM_EN
      if (rdy) chk($sformatf("checksum_d%0d", d), (d == 0) ? cks_a : cks_b, exp_sum[d]);
`endif
    end
    for (int c = 0; c < 3; c++) begin
      av = (c == 0) ? valid_a[0] : (c == 1) ? valid_a[1] : valid_b;
      ae = (c == 0) ? err_a[0] : (c == 1) ? err_a[1] : err_b;
      ad = (c == 0) ? data_a[31:0] : (c == 1) ? data_a[63:32] : data_b;
      rdy = (q[c].size() > 0) && (q[c][0].due == cyc);
      chk($sformatf("rd_valid_c%0d", c), 32'(av), 32'(rdy));
      if (rdy) begin
        e = q[c].pop_front();
        chk($sformatf("rd_err_c%0d", c), 32'(ae), 32'(e.err));
        if (e.known) chk($sformatf("rd_data_c%0d", c), ad, e.data);
      end
    end
    if (rst_n_in) begin
      for (int c = 0; c < 3; c++) begin
        int d;
        d  = dut_c[c];
        rq = (c == 1) ? req_a[1] : req_a[0];
        a  = (c == 1) ? addr_a[63:32] : addr_a[31:0];
        if (rq && !reload && cyc >= ready_from[d]) begin
          widx    = a >> 2;
          e.due   = cyc + lat_c[c];
          e.err   = (widx >= 32'(depth_m[d]));
          e.data  = e.err ? 32'h0 : mem_m[d][widx[2:0]];
          e.known = e.err || known_m[d][widx[2:0]];
          q[c].push_back(e);
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (reload && cyc >= ready_from[d]) begin
          ready_from[d] = BIG; ovf_from[d] = BIG;
          for (int c = 0; c < 3; c++) if (dut_c[c] == d) q[c].delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Streams stream[0..n-1]; the model derives image, completion and overflow times
  task automatic load(input int n, input bit last_en, input int reload_at);
    int s, cap, e, nacc, wi, k, sh;
    s = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      cap  = depth_m[d] * 4;
      e    = (n >= cap) ? cap : (last_en ? n : 0);
      nacc = (n < cap) ? n : cap;
      exp_sum[d] = 32'h0;
      for (int j = 0; j < nacc; j++) begin
        wi = j / 4; k = j % 4;
        sh = be_m[d] ? (3 - k) * 8 : k * 8;
        if (k == 0) mem_m[d][wi] = 32'h0;
        known_m[d][wi] = 1'b1;
        mem_m[d][wi] = mem_m[d][wi] | (32'(stream[j]) << sh);
        exp_sum[d] = exp_sum[d] + 32'(stream[j]);
      end
      if (e > 0) begin
        sysrst_cyc[d] = s + e + 1;
        ready_from[d] = s + e + 2;
      end
      ovf_from[d] = (n > cap) ? s + cap + 1 : BIG;
    end
    for (int j = 0; j < n; j++) begin
      step();
      ld_valid = 1'b1;
      ld_data  = stream[j];
      ld_last  = last_en && (j == n - 1);
      reload   = (j == reload_at);
    end
    step();
    ld_valid = 1'b0; ld_last = 1'b0; reload = 1'b0;
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (!(ready_a && ready_b) && i < 40) begin
      step();
      i++;
    end
    chk("ready_wait", 32'(ready_a && ready_b), 32'd1);
  endtask

  // One request on both ports; checks instance B after 1 cycle and A after 2
  task automatic rd2(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] ea0,
                     input logic eerr_a0, input logic [31:0] ea1, input logic [31:0] eb,
                     input logic eerr_b);
    req_a = 2'b11; addr_a = {a1, a0};
    step();
    req_a = 2'b00;
    chk("lit_a_valid_early", 32'(valid_a), 32'd0);
    chk("lit_b_valid", 32'(valid_b), 32'd1);
    chk("lit_b_err", 32'(err_b), 32'(eerr_b));
    chk("lit_b_data", data_b, eb);
    step();
    chk("lit_a_valid", 32'(valid_a), 32'd3);
    chk("lit_a_err0", 32'(err_a[0]), 32'(eerr_a0));
    chk("lit_a_data0", data_a[31:0], ea0);
    chk("lit_a_data1", data_a[63:32], ea1);
    step();
  endtask

  initial begin
    #1 rst_n_in = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'({ready_a, ready_b}), 32'd0);
    chk("rst_sysrst", 32'({sysrst_a, sysrst_b}), 32'd0);
    chk("rst_valid", 32'({valid_a, valid_b}), 32'd0);
    chk("rst_overflow", 32'({ovf_a, ovf_b}), 32'd0);
    rst_n_in = 1'b1;
    step();

    for (int j = 0; j < 8; j++) stream[j] = 8'(j + 1);
    load(8, 1'b1, -1);
    step();
    chk("lit_sysrst_pulse", 32'({sysrst_a, sysrst_b}), 32'd3);
    chk("lit_not_ready_in_done", 32'({ready_a, ready_b}), 32'd0);
    step();
    chk("lit_ready", 32'({ready_a, ready_b}), 32'd3);
    chk("lit_sysrst_gone", 32'({sysrst_a, sysrst_b}), 32'd0);

    // Back-to-back requests on both ports
    req_a = 2'b11; addr_a = {32'h0, 32'h4};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lit_stream_b", data_b, 32'h08070605);
      if (i >= 1) begin
        chk("lit_stream_a0", data_a[31:0], 32'h05060708);
        chk("lit_stream_a1", data_a[63:32], 32'h01020304);
        chk("lit_stream_aerr", 32'(err_a), 32'd0);
      end
    end
    req_a = 2'b00;
    step(); step();

    // Reload with requests in flight, then a padded partial-word image
    req_a = 2'b11; addr_a = {32'h0, 32'h4};
    step();
    reload = 1'b1;
    step();
    reload = 1'b0; req_a = 2'b00;
    chk("lit_squash_a", 32'(valid_a), 32'd0);
    chk("lit_reload_ready", 32'({ready_a, ready_b}), 32'd0);
    for (int j = 0; j < 6; j++) stream[j] = 8'(8'hAA + 8'(17 * j));
    load(6, 1'b1, -1);
    wait_ready();
    rd2(32'h4, 32'h0, 32'hEEFF0000, 1'b0, 32'hAABBCCDD, 32'h0000FFEE, 1'b0);

    // Overflow on instance A (16-byte capacity); reload during LOAD is ignored
    reload = 1'b1;
    step();
    reload = 1'b0;
    for (int j = 0; j < 20; j++) stream[j] = 8'(8'h10 + 8'(j));
    load(20, 1'b1, 2);
    wait_ready();
    chk("lit_overflow_a", 32'(ovf_a), 32'd1);
    chk("lit_overflow_b", 32'(ovf_b), 32'd0);
    rd2(32'h10, 32'hC, 32'h0, 1'b1, 32'h1C1D1E1F, 32'h23222120, 1'b0);
    rd2(32'hFFFF_FFFC, 32'hF, 32'h0, 1'b1, 32'h1C1D1E1F, 32'h0, 1'b1);

    // Reset in the middle of a load, then a clean reload of 01..08
    reload = 1'b1;
    step();
    reload = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      ld_valid = 1'b1; ld_data = 8'h55;
    end
    step();
    ld_valid = 1'b0;
    rst_n_in = 1'b0;
    step();
    chk("lit_midrst_out", 32'({ready_a, ready_b, ovf_a, ovf_b, sysrst_a, sysrst_b, valid_a, valid_b}), 32'd0);
    step();
    rst_n_in = 1'b1;
    step();
    for (int j = 0; j < 8; j++) stream[j] = 8'(j + 1);
    load(8, 1'b1, -1);
    wait_ready();
    rd2(32'h0, 32'h5, 32'h01020304, 1'b0, 32'h05060708, 32'h04030201, 1'b0);
`ifdef PROGMEM_CHECKSUM_EN
    chk("lit_checksum_a", cks_a, 32'h24);
    chk("lit_checksum_b", cks_b, 32'h24);
`endif
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
